// File: rtl/division_sequencer.sv
// division_sequencer: execute-stage controller that drives the iterative
// divider for DIV/DIVU/REM/REMU. It latches the operands, pulses the divider's
// activate input, stalls the pipeline until the divider finishes, and then
// either writes the result back or raises a divide-by-zero trap. A pipeline
// flush (abort) suppresses the outcome of an in-flight operation.
module division_sequencer (
  input  logic        clock,
  input  logic        reset,
  // Execute-stage request
  input  logic        start,
  input  logic [1:0]  opcode,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  destReg,
  input  logic        abort,
  output logic        busy,
  // Divider handshake
  output logic [31:0] divLeftOperand,
  output logic [31:0] divRightOperand,
  output logic        divIsSigned,
  output logic        divActivate,
  input  logic        divDone,
  input  logic [31:0] divQuotient,
  input  logic [31:0] divRemainder,
  input  logic        divDivisionByZero,
  // Writeback / exception
  output logic        wbValid,
  output logic [4:0]  wbReg,
  output logic [31:0] wbData,
  output logic        trapDivZero
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    WAIT,
    RESULT
  } seqState_t;

  seqState_t   state;
  logic        isRemainder;   // opcode[1] of the accepted instruction
  logic [4:0]  destRegLatch;  // writeback index of the accepted instruction
  logic        aborted;       // a flush hit this operation before RESULT
  logic        wbPending;     // writeback armed for the RESULT cycle
  logic        trapPending;   // trap armed for the RESULT cycle

  // A flush arriving in the RESULT cycle itself still has to cancel the
  // outcome, so the armed pulses are gated combinationally by abort.
  assign wbValid     = wbPending & ~abort;
  assign trapDivZero = trapPending & ~abort;

  // Sequencer FSM: operand capture, launch, settle, poll, and result staging.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      divActivate     <= 1'b0;
      divLeftOperand  <= 32'd0;
      divRightOperand <= 32'd0;
      divIsSigned     <= 1'b0;
      isRemainder     <= 1'b0;
      destRegLatch    <= 5'd0;
      aborted         <= 1'b0;
      wbPending       <= 1'b0;
      trapPending     <= 1'b0;
      wbReg           <= 5'd0;
      wbData          <= 32'd0;
    end else begin
      // Pulses default low; the state that needs them raises them.
      divActivate <= 1'b0;
      wbPending   <= 1'b0;
      trapPending <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            divLeftOperand  <= operandA;
            divRightOperand <= operandB;
            divIsSigned     <= ~opcode[0];
            isRemainder     <= opcode[1];
            destRegLatch    <= destReg;
            aborted         <= 1'b0;
            busy            <= 1'b1;
            divActivate     <= 1'b1;
            state           <= LAUNCH;
          end
        end
        LAUNCH: begin
          aborted <= aborted | abort;
          state   <= SETTLE;
        end
        SETTLE: begin
          // divDone may still be high from the previous operation here;
          // it is deliberately not looked at until WAIT.
          aborted <= aborted | abort;
          state   <= WAIT;
        end
        WAIT: begin
          aborted <= aborted | abort;
          if (divDone) begin
            state <= RESULT;
            if (!(aborted || abort)) begin
              if (divDivisionByZero) begin
                trapPending <= 1'b1;
              end else begin
                wbPending <= 1'b1;
                wbReg     <= destRegLatch;
                wbData    <= isRemainder ? divRemainder : divQuotient;
              end
            end
          end
        end
        RESULT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_division_sequencer.sv
// tb_division_sequencer: directed bench for division_sequencer with a
// behavioural divider and a cycle-numbered expectation model.
module tb_division_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  opcode;
  logic [31:0] operandA, operandB;
  logic [4:0]  destReg;
  logic        busy, divActivate, divIsSigned;
  logic [31:0] divLeftOperand, divRightOperand;
  logic        divDone = 1'b0;
  logic [31:0] divQuotient = 32'd0;
  logic [31:0] divRemainder = 32'd0;
  logic        divDivisionByZero = 1'b0;
  logic        wbValid, trapDivZero;
  logic [4:0]  wbReg;
  logic [31:0] wbData;

  int errors = 0;
  int checks = 0;

  division_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .operandA(operandA), .operandB(operandB), .destReg(destReg),
    .abort(abort), .busy(busy),
    .divLeftOperand(divLeftOperand), .divRightOperand(divRightOperand),
    .divIsSigned(divIsSigned), .divActivate(divActivate), .divDone(divDone),
    .divQuotient(divQuotient), .divRemainder(divRemainder),
    .divDivisionByZero(divDivisionByZero),
    .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData),
    .trapDivZero(trapDivZero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference divider results {divisionByZero, quotient, remainder}
  function automatic logic [64:0] divRef(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFFFFFF, a};
    if (sgn) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b0, 32'h80000000, 32'd0};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {1'b0, q, r};
  endfunction

  // Behavioural divider: restarts on activate, drops a stale done one cycle
  // late (so the sequencer must mask it), finishes DivLatency edges later.
  localparam int DivLatency = 5;
  int          divCnt = 0;
  bit          divRunning = 1'b0;
  logic [31:0] divA = 32'd0, divB = 32'd0;
  logic        divS = 1'b0;
  always @(posedge clock) begin
    if (divActivate === 1'b1) begin
      divRunning <= 1'b1;
      divCnt     <= 1;
      divA       <= divLeftOperand;
      divB       <= divRightOperand;
      divS       <= divIsSigned;
    end else if (divRunning) begin
      divCnt <= divCnt + 1;
      if (divCnt + 1 == 2) divDone <= 1'b0;
      if (divCnt + 1 == DivLatency) begin
        divDone <= 1'b1;
        {divDivisionByZero, divQuotient, divRemainder} <= divRef(divS, divA, divB);
        divRunning <= 1'b0;
      end
    end
  end

  // Expectation model and monitor: checks every cycle at the falling edge.
  int          cyc = 0, acceptCyc = 0, resultCyc = -1, k = 0;
  bit          opActive = 1'b0, expectResetVals = 1'b0, mAborted = 1'b0;
  logic [1:0]  mOp;
  logic [31:0] mA, mB;
  logic [4:0]  mRd;
  logic [64:0] res;
  logic        okOut, expWb, expTrap;
  int          actCount = 0, wbCount = 0, trapCount = 0, busyCycles = 0, lastLatency = -1;
  logic [31:0] lastWbData = 32'd0;
  logic [4:0]  lastWbReg = 5'd0;

  always @(negedge clock) begin
    cyc++;
    k = cyc - acceptCyc;
    if (divActivate === 1'b1) actCount++;
    if (busy === 1'b1) busyCycles++;
    if (trapDivZero === 1'b1) trapCount++;
    if (wbValid === 1'b1) begin
      wbCount++;
      lastWbData  = wbData;
      lastWbReg   = wbReg;
      lastLatency = cyc - acceptCyc;
    end
    if (expectResetVals) begin
      check("rst_wbReg", {27'd0, wbReg}, 32'd0);
      check("rst_wbData", wbData, 32'd0);
      check("rst_left", divLeftOperand, 32'd0);
      check("rst_right", divRightOperand, 32'd0);
      check("rst_signed", {31'd0, divIsSigned}, 32'd0);
    end
    if (!opActive) begin
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_activate", {31'd0, divActivate}, 32'd0);
      check("idle_wbValid", {31'd0, wbValid}, 32'd0);
      check("idle_trap", {31'd0, trapDivZero}, 32'd0);
    end else if (k >= 1) begin
      check("op_busy", {31'd0, busy}, 32'd1);
      check("op_activate", {31'd0, divActivate}, {31'd0, k == 1});
      check("op_left", divLeftOperand, mA);
      check("op_right", divRightOperand, mB);
      check("op_signed", {31'd0, divIsSigned}, {31'd0, ~mOp[0]});
      res = divRef(~mOp[0], mA, mB);
      if (cyc == resultCyc) begin
        okOut   = !mAborted && !abort;
        expWb   = okOut && !res[64];
        expTrap = okOut && res[64];
        check("res_wbValid", {31'd0, wbValid}, {31'd0, expWb});
        check("res_trap", {31'd0, trapDivZero}, {31'd0, expTrap});
        if (expWb) begin
          check("res_wbReg", {27'd0, wbReg}, {27'd0, mRd});
          check("res_wbData", wbData, mOp[1] ? res[31:0] : res[63:32]);
        end
      end else begin
        check("op_wbValid", {31'd0, wbValid}, 32'd0);
        check("op_trap", {31'd0, trapDivZero}, 32'd0);
      end
    end
    // Advance the model for the edge that ends this cycle.
    if (reset) begin
      opActive        = 1'b0;
      expectResetVals = 1'b1;
    end else begin
      expectResetVals = 1'b0;
      if (opActive) begin
        if (cyc == resultCyc) opActive = 1'b0;
        else begin
          mAborted = mAborted | abort;
          if (resultCyc < 0 && k >= 3 && divDone) resultCyc = cyc + 1;
        end
      end else if (start && !abort) begin
        opActive  = 1'b1;
        acceptCyc = cyc;
        resultCyc = -1;
        mAborted  = 1'b0;
        mOp = opcode; mA = operandA; mB = operandB; mRd = destReg;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction and run until busy drops. abortK/startK/resetK name
  // the cycle (1 = LAUNCH) where that disturbance is applied; -1 = never.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int abortK, input int startK, input int resetK);
    bit finished;
    actCount = 0; wbCount = 0; trapCount = 0; busyCycles = 0; lastLatency = -1;
    opcode = op; operandA = a; operandB = b; destReg = rd; start = 1'b1; abort = 1'b0;
    tick();
    start = 1'b0;
    finished = 1'b0;
    for (int i = 1; i < 200 && !finished; i++) begin
      if (busy !== 1'b1) finished = 1'b1;
      else begin
        abort = (i == abortK);
        reset = (i == resetK);
        if (i == startK) begin
          start = 1'b1; opcode = 2'b01; operandA = 32'h12345678; operandB = 32'h11; destReg = 5'd3;
        end else start = 1'b0;
        tick();
      end
    end
    abort = 1'b0; reset = 1'b0; start = 1'b0;
    if (!finished) begin
      errors++; checks++;
      $display("FAIL issue_timeout: busy still 1 after 200 cycles, required 0");
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; opcode = 2'b00;
    operandA = 32'd0; operandB = 32'd0; destReg = 5'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);

    // DIVU 25/4 -> 6 into x7, latency start+7, busy for 7 cycles
    issue(2'b01, 32'd25, 32'd4, 5'd7, -1, -1, -1);
    check("divu_act", actCount, 1);
    check("divu_wbcount", wbCount, 1);
    check("divu_reg", {27'd0, lastWbReg}, 32'd7);
    check("divu_data", lastWbData, 32'd6);
    check("divu_latency", lastLatency, 7);
    check("divu_busy", busyCycles, 7);

    // Signed REM -7 % 3 = -1, then DIV -7/3 = -2 (stale done must be masked)
    issue(2'b10, 32'hFFFFFFF9, 32'd3, 5'd5, -1, -1, -1);
    check("rem_data", lastWbData, 32'hFFFFFFFF);
    issue(2'b00, 32'hFFFFFFF9, 32'd3, 5'd5, -1, -1, -1);
    check("div_data", lastWbData, 32'hFFFFFFFE);
    check("div_latency", lastLatency, 7);

    // Divide by zero traps, then a normal op writes back
    issue(2'b00, 32'd1, 32'd0, 5'd2, -1, -1, -1);
    check("dz_trap", trapCount, 1);
    check("dz_wb", wbCount, 0);
    issue(2'b01, 32'd1, 32'd1, 5'd2, -1, -1, -1);
    check("one_wb", wbCount, 1);
    check("one_data", lastWbData, 32'd1);
    check("one_trap", trapCount, 0);

    // Abort in WAIT: busy held to completion, nothing reported
    issue(2'b01, 32'h9999999A, 32'd3, 5'd4, 4, -1, -1);
    check("abort_wb", wbCount, 0);
    check("abort_trap", trapCount, 0);
    check("abort_busy", busyCycles, 7);
    issue(2'b11, 32'h99999999, 32'h88888888, 5'd4, -1, -1, -1);
    check("remu_data", lastWbData, 32'h11111111);

    // start during WAIT is ignored; MIN / -1
    issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd6, -1, 4, -1);
    check("ign_act", actCount, 1);
    check("ign_wbcount", wbCount, 1);
    check("ign_data", lastWbData, 32'h80000000);

    // Abort in the RESULT cycle cancels the writeback
    issue(2'b01, 32'd7, 32'd2, 5'd8, 7, -1, -1);
    check("abort_res_wb", wbCount, 0);

    // start together with abort in IDLE is not accepted
    actCount = 0;
    start = 1'b1; abort = 1'b1; opcode = 2'b01; operandA = 32'd9; operandB = 32'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    check("start_abort_act", actCount, 0);

    // Reset in WAIT, then a clean DIVU 100/10
    issue(2'b01, 32'd50, 32'd7, 5'd1, -1, -1, 4);
    check("reset_mid_wb", wbCount, 0);
    issue(2'b01, 32'd100, 32'd10, 5'd9, -1, -1, -1);
    check("after_rst_data", lastWbData, 32'd10);
    check("after_rst_reg", {27'd0, lastWbReg}, 32'd9);
    check("after_rst_latency", lastLatency, 7);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
